// File: rtl/cuba_lif_pkg.sv
// Shared state encoding, width formulas and saturating arithmetic for the
// time-multiplexed CUBA LIF layer core.
package cuba_lif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ACC,
    DRAIN,
    UPDATE,
    DONE
  } lif_state_t;

  localparam logic RESET_TO_VREST = 1'b0;
  localparam logic RESET_SUBTRACT = 1'b1;

  function automatic int calc_wt_precision(input int dec_bits);
    return 1 + dec_bits;
  endfunction

  function automatic int calc_precision(input int int_bits, input int dec_bits);
    return 1 + int_bits + dec_bits;
  endfunction

  function automatic int calc_acc_width(input int precision, input int fanin);
    return precision + $clog2(fanin);
  endfunction

  function automatic int calc_nid_width(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

  function automatic int calc_addr_width(input int fanin);
    return $clog2(fanin);
  endfunction

  // Adds two wide signed values and clamps the sum to a signed range of 'width' bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/cuba_lif_array_neuron_dp.sv
// Combinational single-neuron update: current and membrane leak, saturating
// integration, threshold test, reset mechanism and refractory hold.
module cuba_neuron_dp
  import cuba_lif_pkg::*;
#(
  parameter int PRECISION         = 8,
  parameter int DECIMAL_PRECISION = 4,
  parameter int ACC_WIDTH         = 16,
  parameter int REF_WIDTH         = 4
) (
  input  logic signed [PRECISION-1:0] cur,
  input  logic signed [PRECISION-1:0] vmem,
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [REF_WIDTH-1:0] ref_cnt,
  input  logic signed [PRECISION-1:0] vth,
  input  logic signed [PRECISION-1:0] decay_rate,
  input  logic signed [PRECISION-1:0] cur_decay,
  input  logic signed [PRECISION-1:0] vrest,
  input  logic                        reset_mechanism,
  input  logic        [REF_WIDTH-1:0] refractory_period,
  output logic signed [PRECISION-1:0] cur_next,
  output logic signed [PRECISION-1:0] vmem_next,
  output logic        [REF_WIDTH-1:0] ref_next,
  output logic                        spike
);

  logic signed [2*PRECISION-1:0] cur_prod;
  logic signed [2*PRECISION-1:0] vmem_prod;
  logic signed [63:0]            cur_leak;
  logic signed [63:0]            vmem_leak;
  logic signed [PRECISION-1:0]   cur_sat;
  logic signed [PRECISION-1:0]   vmem_sat;
  logic signed [PRECISION-1:0]   vsub_sat;

  // Leaks use full-width products; the un-saturated leaked value feeds the saturating add.
  always_comb begin
    cur_prod  = cur * cur_decay;
    vmem_prod = vmem * decay_rate;
    cur_leak  = 64'(cur) - 64'(cur_prod >>> DECIMAL_PRECISION);
    vmem_leak = 64'(vmem) - 64'(vmem_prod >>> DECIMAL_PRECISION);
    cur_sat   = PRECISION'(sat_add(cur_leak, 64'(acc), PRECISION));
    vmem_sat  = PRECISION'(sat_add(vmem_leak, 64'(cur_sat), PRECISION));
    vsub_sat  = PRECISION'(sat_add(64'(vmem_sat), -64'(vth), PRECISION));

    cur_next  = cur_sat;
    vmem_next = vmem_sat;
    ref_next  = ref_cnt;
    spike     = 1'b0;

    if (ref_cnt != '0) begin
      vmem_next = vrest;
      ref_next  = ref_cnt - REF_WIDTH'(1);
    end else if (vmem_sat >= vth) begin
      spike     = 1'b1;
      vmem_next = (reset_mechanism == RESET_SUBTRACT) ? vsub_sat : vrest;
      ref_next  = refractory_period;
    end
  end

endmodule

// File: rtl/cuba_lif_array.sv
// Time-multiplexed array of current-based LIF neurons sharing one input spike
// vector; weights live in one RAM and only spiking inputs are accumulated.
module cuba_lif_array
  import cuba_lif_pkg::*;
#(
  parameter  int NUM_NEURONS       = 16,
  parameter  int FANIN             = 256,
  parameter  int INTEGER_PRECISION = 3,
  parameter  int DECIMAL_PRECISION = 4,
  parameter  int REF_WIDTH         = 4,
  localparam int WT_PRECISION      = calc_wt_precision(DECIMAL_PRECISION),
  localparam int PRECISION         = calc_precision(INTEGER_PRECISION, DECIMAL_PRECISION),
  localparam int ACC_WIDTH         = calc_acc_width(PRECISION, FANIN),
  localparam int NID_WIDTH         = calc_nid_width(NUM_NEURONS),
  localparam int ADDR_WIDTH        = calc_addr_width(FANIN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [PRECISION-1:0] vth,
  input  logic signed [PRECISION-1:0] decay_rate,
  input  logic signed [PRECISION-1:0] cur_decay,
  input  logic signed [PRECISION-1:0] vrest,
  input  logic                        reset_mechanism,
  input  logic        [REF_WIDTH-1:0] refractory_period,
  input  logic                        wr_en,
  input  logic        [NID_WIDTH-1:0] wr_nid,
  input  logic       [ADDR_WIDTH-1:0] wr_addr,
  input  logic     [WT_PRECISION-1:0] wr_data,
  input  logic                        step_start,
  input  logic            [FANIN-1:0] inspk,
  output logic                        busy,
  output logic                        step_done,
  output logic      [NUM_NEURONS-1:0] outspk,
  input  logic        [NID_WIDTH-1:0] vmem_rd_nid,
  output logic        [PRECISION-1:0] vmem_rd_data
);

  lif_state_t state;
  lif_state_t state_next;

  logic            [FANIN-1:0] spk_lat;
  logic       [ADDR_WIDTH-1:0] scan_i;
  logic        [NID_WIDTH-1:0] nid_cnt;
  logic                        scan_last;
  logic                        nid_last;
  logic                        rd_issue;
  logic                        scan_step;
  logic        [NID_WIDTH-1:0] rd_nid;
  logic                        rd_valid;
  logic        [NID_WIDTH-1:0] rd_vnid;
  logic     [WT_PRECISION-1:0] rd_data;
  logic signed [ACC_WIDTH-1:0] weight_ext;

  logic     [WT_PRECISION-1:0] wram     [NUM_NEURONS][FANIN];
  logic signed [PRECISION-1:0] cur_mem  [NUM_NEURONS];
  logic signed [PRECISION-1:0] vmem_mem [NUM_NEURONS];
  logic        [REF_WIDTH-1:0] ref_mem  [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] acc_mem  [NUM_NEURONS];
  logic      [NUM_NEURONS-1:0] spk_new;
  logic                        vmem_init;

  logic signed [PRECISION-1:0] dp_cur;
  logic signed [PRECISION-1:0] dp_vmem;
  logic        [REF_WIDTH-1:0] dp_ref;
  logic                        dp_spike;

  assign scan_last  = (scan_i == ADDR_WIDTH'(FANIN - 1));
  assign nid_last   = (nid_cnt == NID_WIDTH'(NUM_NEURONS - 1));
  assign rd_nid     = (state == SCAN) ? '0 : nid_cnt;
  assign weight_ext = {{(ACC_WIDTH - WT_PRECISION){rd_data[WT_PRECISION-1]}}, rd_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A spiking input costs one read per neuron: neuron 0 is read from SCAN, the rest from ACC.
  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    scan_step  = 1'b0;
    case (state)
      IDLE: if (step_start) state_next = SCAN;
      SCAN: begin
        if (spk_lat[scan_i]) begin
          rd_issue = 1'b1;
          if (NUM_NEURONS == 1) begin
            scan_step  = 1'b1;
            state_next = scan_last ? DRAIN : SCAN;
          end else begin
            state_next = ACC;
          end
        end else begin
          scan_step  = 1'b1;
          state_next = scan_last ? DRAIN : SCAN;
        end
      end
      ACC: begin
        rd_issue = 1'b1;
        if (nid_last) begin
          scan_step  = 1'b1;
          state_next = scan_last ? DRAIN : SCAN;
        end
      end
      DRAIN:   state_next = UPDATE;
      UPDATE:  if (nid_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weight RAM: writes land before a same-cycle step accept, so that step sees them.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (int'(wr_nid) < NUM_NEURONS)) wram[wr_nid][wr_addr] <= wr_data;
    if (rd_issue) rd_data <= wram[rd_nid][scan_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_lat      <= '0;
      scan_i       <= '0;
      nid_cnt      <= '0;
      rd_valid     <= 1'b0;
      rd_vnid      <= '0;
      busy         <= 1'b0;
      step_done    <= 1'b0;
      outspk       <= '0;
      vmem_rd_data <= '0;
    end else begin
      rd_valid  <= rd_issue;
      rd_vnid   <= rd_nid;
      step_done <= 1'b0;
      if (int'(vmem_rd_nid) < NUM_NEURONS) vmem_rd_data <= vmem_mem[vmem_rd_nid];
      else                                 vmem_rd_data <= '0;
      case (state)
        IDLE: begin
          if (step_start) begin
            spk_lat <= inspk;
            scan_i  <= '0;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          nid_cnt <= NID_WIDTH'(1);
          if (scan_step) scan_i <= scan_i + ADDR_WIDTH'(1);
        end
        ACC: begin
          nid_cnt <= nid_cnt + NID_WIDTH'(1);
          if (scan_step) scan_i <= scan_i + ADDR_WIDTH'(1);
        end
        DRAIN:  nid_cnt <= '0;
        UPDATE: nid_cnt <= nid_cnt + NID_WIDTH'(1);
        DONE: begin
          outspk    <= spk_new;
          step_done <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Membrane potentials take vrest on the first edge after reset, then only change in UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        cur_mem[n]  <= '0;
        vmem_mem[n] <= '0;
        ref_mem[n]  <= '0;
        acc_mem[n]  <= '0;
      end
      spk_new   <= '0;
      vmem_init <= 1'b1;
    end else begin
      if (vmem_init) begin
        for (int n = 0; n < NUM_NEURONS; n++) vmem_mem[n] <= vrest;
        vmem_init <= 1'b0;
      end
      if (state == IDLE && step_start) begin
        for (int n = 0; n < NUM_NEURONS; n++) acc_mem[n] <= '0;
      end else if (rd_valid) begin
        acc_mem[rd_vnid] <= acc_mem[rd_vnid] + weight_ext;
      end
      if (state == UPDATE) begin
        cur_mem[nid_cnt]  <= dp_cur;
        vmem_mem[nid_cnt] <= dp_vmem;
        ref_mem[nid_cnt]  <= dp_ref;
        spk_new[nid_cnt]  <= dp_spike;
      end
    end
  end

  cuba_neuron_dp #(
    .PRECISION         (PRECISION),
    .DECIMAL_PRECISION (DECIMAL_PRECISION),
    .ACC_WIDTH         (ACC_WIDTH),
    .REF_WIDTH         (REF_WIDTH)
  ) u_dp (
    .cur               (cur_mem[nid_cnt]),
    .vmem              (vmem_mem[nid_cnt]),
    .acc               (acc_mem[nid_cnt]),
    .ref_cnt           (ref_mem[nid_cnt]),
    .vth               (vth),
    .decay_rate        (decay_rate),
    .cur_decay         (cur_decay),
    .vrest             (vrest),
    .reset_mechanism   (reset_mechanism),
    .refractory_period (refractory_period),
    .cur_next          (dp_cur),
    .vmem_next         (dp_vmem),
    .ref_next          (dp_ref),
    .spike             (dp_spike)
  );

endmodule

// File: tb/tb_cuba_lif_array.sv
// Self-checking bench for cuba_lif_array: directed scenarios plus randomized
// steps compared against an arithmetic model of the neuron equations.
module tb_cuba_lif_array;

  localparam int NN = 2;
  localparam int FI = 4;
  localparam int DP = 4;
  localparam int RW = 4;
  localparam int P  = 8;
  localparam int WT = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [P-1:0]  vth;
  logic signed [P-1:0]  decay_rate;
  logic signed [P-1:0]  cur_decay;
  logic signed [P-1:0]  vrest;
  logic                 reset_mechanism;
  logic [RW-1:0]        refractory_period;
  logic                 wr_en;
  logic                 wr_nid;
  logic [1:0]           wr_addr;
  logic [WT-1:0]        wr_data;
  logic                 step_start;
  logic [FI-1:0]        inspk;
  logic                 busy;
  logic                 step_done;
  logic [NN-1:0]        outspk;
  logic                 vmem_rd_nid;
  logic [P-1:0]         vmem_rd_data;

  int checks   = 0;
  int failures = 0;

  int            mw [NN][FI];
  int            mi [NN];
  int            mv [NN];
  int            mr [NN];
  logic [NN-1:0] mspk;

  cuba_lif_array #(
    .NUM_NEURONS       (NN),
    .FANIN             (FI),
    .INTEGER_PRECISION (3),
    .DECIMAL_PRECISION (DP),
    .REF_WIDTH         (RW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .vth               (vth),
    .decay_rate        (decay_rate),
    .cur_decay         (cur_decay),
    .vrest             (vrest),
    .reset_mechanism   (reset_mechanism),
    .refractory_period (refractory_period),
    .wr_en             (wr_en),
    .wr_nid            (wr_nid),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .step_start        (step_start),
    .inspk             (inspk),
    .busy              (busy),
    .step_done         (step_done),
    .outspk            (outspk),
    .vmem_rd_nid       (vmem_rd_nid),
    .vmem_rd_data      (vmem_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NN; n++) begin
      mi[n] = 0;
      mv[n] = int'(vrest);
      mr[n] = 0;
    end
    mspk = '0;
  endtask

  // One timestep of every neuron, straight from the neuron equations.
  task automatic model_step(input logic [FI-1:0] s);
    int acc, id, vd, ip, vp;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int i = 0; i < FI; i++) if (s[i]) acc += mw[n][i];
      id = mi[n] - ((mi[n] * int'(cur_decay)) >>> DP);
      vd = mv[n] - ((mv[n] * int'(decay_rate)) >>> DP);
      ip = clamp(id + acc);
      vp = clamp(vd + ip);
      mspk[n] = 1'b0;
      if (mr[n] != 0) begin
        mv[n] = int'(vrest);
        mr[n] = mr[n] - 1;
      end else if (vp >= int'(vth)) begin
        mspk[n] = 1'b1;
        mv[n]   = reset_mechanism ? clamp(vp - int'(vth)) : int'(vrest);
        mr[n]   = int'(refractory_period);
      end else begin
        mv[n] = vp;
      end
      mi[n] = ip;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_weight(input int n, input int a, input int d);
    wr_en   = 1'b1;
    wr_nid  = n[0];
    wr_addr = a[1:0];
    wr_data = d[WT-1:0];
    tick();
    wr_en   = 1'b0;
    mw[n][a] = d;
  endtask

  // Runs one step; with 'inject' set, a step_start and a weight write are attempted mid-step.
  task automatic apply_stimulus(input logic [FI-1:0] s, input bit inject);
    int lat;
    int exp_lat;
    exp_lat    = FI + $countones(s) * (NN - 1) + NN + 2;
    step_start = 1'b1;
    inspk      = s;
    tick();
    step_start = 1'b0;
    inspk      = FI'($urandom);
    lat        = 0;
    while (lat < 200) begin
      if (inject && lat == 2) begin
        step_start = 1'b1;
        wr_en      = 1'b1;
        wr_nid     = 1'b0;
        wr_addr    = 2'd0;
        wr_data    = 5'b10000;
      end else begin
        step_start = 1'b0;
        wr_en      = 1'b0;
      end
      tick();
      lat++;
      if (step_done) break;
    end
    step_start = 1'b0;
    wr_en      = 1'b0;
    model_step(s);
    check_val("latency", lat, exp_lat);
    check_val("outspk", outspk, mspk);
    check_val("busy_after_done", busy, 0);
  endtask

  task automatic check_output(input int n);
    vmem_rd_nid = n[0];
    tick();
    check_val($sformatf("vmem%0d", n), $signed(vmem_rd_data), mv[n]);
  endtask

  initial begin
    int dones;
    int tmp;
    rst = 1'b1;
    wr_en = 1'b0; wr_nid = 1'b0; wr_addr = '0; wr_data = '0;
    step_start = 1'b0; inspk = '0; vmem_rd_nid = 1'b0;
    vth = 8'sd32; decay_rate = '0; cur_decay = '0; vrest = '0;
    reset_mechanism = 1'b0; refractory_period = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("[TB] reset state");
    check_val("busy_reset", busy, 0);
    check_val("done_reset", step_done, 0);
    check_val("outspk_reset", outspk, 0);
    check_output(0);
    check_output(1);

    $display("[TB] integration towards threshold, reset to vrest");
    for (int n = 0; n < NN; n++) for (int a = 0; a < FI; a++) write_weight(n, a, 0);
    write_weight(0, 1, 8);
    write_weight(1, 1, -8);
    for (int s = 0; s < 3; s++) begin
      apply_stimulus(4'b0010, 1'b0);
      check_output(0);
      check_output(1);
    end

    $display("[TB] subtract-threshold reset");
    do_reset();
    reset_mechanism = 1'b1;
    for (int s = 0; s < 3; s++) apply_stimulus(4'b0010, 1'b0);
    check_output(0);
    check_output(1);

    $display("[TB] refractory hold");
    do_reset();
    reset_mechanism   = 1'b0;
    refractory_period = 4'd2;
    for (int a = 0; a < FI; a++) write_weight(0, a, 15);
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(4'b1111, 1'b0);
      check_output(0);
    end

    $display("[TB] saturation and empty step");
    do_reset();
    refractory_period = '0;
    reset_mechanism   = 1'b1;
    vth               = 8'sd100;
    for (int n = 0; n < NN; n++) for (int a = 0; a < FI; a++) write_weight(n, a, 15);
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(4'b1111, 1'b0);
      check_output(0);
      check_output(1);
    end
    apply_stimulus(4'b0000, 1'b0);

    $display("[TB] reset during accumulation");
    step_start = 1'b1;
    inspk      = 4'b1111;
    tick();
    step_start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("busy_abort", busy, 0);
    check_val("done_abort", step_done, 0);
    tick();
    rst = 1'b0;
    model_reset();
    dones = 0;
    repeat (20) begin
      tick();
      if (step_done) dones++;
    end
    check_val("no_done_after_abort", dones, 0);
    check_output(0);

    $display("[TB] requests while busy are dropped");
    write_weight(0, 0, 5);
    apply_stimulus(4'b0001, 1'b1);
    check_output(0);
    apply_stimulus(4'b0001, 1'b0);
    check_output(0);

    $display("[TB] randomized steps");
    for (int r = 0; r < 24; r++) begin
      if (r % 6 == 0) begin
        for (int n = 0; n < NN; n++)
          for (int a = 0; a < FI; a++) write_weight(n, a, int'($urandom_range(31, 0)) - 16);
      end
      vth               = 8'($urandom_range(80, 8));
      decay_rate        = 8'($urandom_range(15, 0));
      cur_decay         = 8'($urandom_range(15, 0));
      tmp               = int'($urandom_range(24, 0)) - 12;
      vrest             = tmp[7:0];
      reset_mechanism   = 1'($urandom_range(1, 0));
      refractory_period = 4'($urandom_range(3, 0));
      apply_stimulus(FI'($urandom), 1'b0);
      check_output(0);
      check_output(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cuba_lif_array.md
Name: cuba_lif_array

Overview:
- Time-multiplexed array of NUM_NEURONS current-based LIF neurons sharing one FANIN-input spike vector.
- Holds a per-neuron synaptic weight RAM, plus per-neuron synaptic current, membrane potential and refractory counter.
- Processes one timestep per step_start handshake and skips non-spiking inputs.
- Next-generation single-clock layer core, replacing per-neuron instances with separate memory and spike clocks.

Parameters:
- NUM_NEURONS, 16, neurons in the array (>=1).
- FANIN, 256, presynaptic inputs per neuron.
- INTEGER_PRECISION, 3, integer bits of state variables.
- DECIMAL_PRECISION, 4, fraction bits of weights and state.
- REF_WIDTH, 4, refractory counter width.
- Local WT_PRECISION = 1+DECIMAL_PRECISION, signed weight.
- Local PRECISION = 1+INTEGER_PRECISION+DECIMAL_PRECISION, signed state.
- Local ACC_WIDTH = PRECISION+$clog2(FANIN).
- Local NID_WIDTH = max(1,$clog2(NUM_NEURONS)).
- Local ADDR_WIDTH = $clog2(FANIN).

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vth  in  PRECISION  signed threshold.
- decay_rate  in  PRECISION  membrane leak factor.
- cur_decay  in  PRECISION  synaptic-current leak factor.
- vrest  in  PRECISION  resting and reset potential.
- reset_mechanism  in  1  0 = reset to vrest, 1 = subtract vth.
- refractory_period  in  REF_WIDTH  steps held after a spike.
- wr_en  in  1  weight write strobe.
- wr_nid  in  NID_WIDTH  target neuron.
- wr_addr  in  ADDR_WIDTH  presynaptic index.
- wr_data  in  WT_PRECISION  signed weight.
- step_start  in  1  begin timestep.
- inspk  in  FANIN  input spike vector, sampled on accept.
- busy  out  1  step in progress.
- step_done  out  1  one-cycle completion pulse.
- outspk  out  NUM_NEURONS  registered output spikes of the last step.
- vmem_rd_nid  in  NID_WIDTH  membrane read select.
- vmem_rd_data  out  PRECISION  registered vmem of the selected neuron.

Behaviour:
- Reset, asynchronous:
  - FSM returns to IDLE; busy, step_done, outspk and vmem_rd_data go to 0.
  - All v go to vrest as sampled at the first post-reset edge; until then they read 0.
  - All I, refractory counters and accumulators go to 0.
  - Weight RAM is not reset.
  - Reset mid-step aborts the step; no step_done is produced.
- FSM states: IDLE, SCAN, ACC, DRAIN, UPDATE, DONE.
- IDLE:
  - step_start=1 is accepted: latch inspk, clear all accumulators, busy=1 from the next cycle, enter SCAN with i=0.
  - step_start while busy is ignored.
- SCAN, index i:
  - If latched bit i is 0, increment i (1 cycle).
  - If bit i is 1, enter ACC.
- ACC: issue synchronous RAM reads for n=0..NUM_NEURONS-1 (one per cycle, 1-cycle read latency, pipelined). Each returned weight is sign-extended to ACC_WIDTH and added to acc[n]. Then i++ and return to SCAN.
- SCAN exit: after i=FANIN-1, go to DRAIN (1 cycle, retires the last read).
- UPDATE: one neuron per cycle, n=0..NUM_NEURONS-1, in this order:
  - Leak: Id = I - ((I*cur_decay)>>>DECIMAL_PRECISION); vd = v - ((v*decay_rate)>>>DECIMAL_PRECISION). Products are full width; shifts are arithmetic.
  - I' = sat(Id + acc[n]); v' = sat(vd + I'). sat clamps to the signed PRECISION range.
  - If ref[n] != 0: v = vrest, ref--, spike=0.
  - Else if v' >= vth (signed): spike=1; v = vrest (mode 0) or sat(v' - vth) (mode 1); ref = refractory_period.
  - Else: v = v', spike=0.
  - I is always updated to I'.
- DONE, 1 cycle: outspk takes the new spike vector, step_done=1, busy=0.
- Latency: with k spiking inputs, step_done asserts T = FANIN + k*(NUM_NEURONS-1) + NUM_NEURONS + 2 cycles after the accept edge.
- Back-to-back: step_start may be asserted in the cycle after step_done.
- Weight writes:
  - Accepted only when busy=0 (1-cycle write).
  - Writes while busy are dropped.
  - A write and a step_start in the same IDLE cycle: the write is performed first and is visible to that step.
- vmem_rd_data is updated every cycle from vmem_rd_nid, 1-cycle latency. Mid-UPDATE reads may show old or new values.

Decomposition:
- Package cuba_lif_pkg holds:
  - FSM state encoding.
  - Precision localparam formulas.
  - A saturating-add function parameterised by width.
  - Reset-mechanism codes.
- One sub-module, cuba_neuron_dp: the combinational single-neuron update (leak, saturation, threshold, refractory) from the UPDATE step.

Test Plan (INT=3, DEC=4, so 1.0=16; NUM_NEURONS=2, FANIN=4):
- Reset, then read both neurons with vrest=0 -> vmem_rd_data=0, outspk=00, busy=0.
- Write w[0][1]=8 and w[1][1]=-8; decays 0; vth=32; inspk=0010 -> step_done exactly 9 cycles after accept; v0=8, v1=-8, outspk=00.
- Continue the previous state and repeat the step: I0=16, v0=24; third step: I0=24, v0=48 >= 32 -> outspk[0]=1, v0=vrest (mode 0); with mode 1, v0=16.
- refractory_period=2 after a spike -> next 2 steps v0=vrest and outspk[0]=0, even with large input; spiking resumes on the 3rd step.
- Weights all 15, inspk=1111, repeated steps -> I and v saturate at 127 with no wrap; inspk=0000 -> step_done after 8 cycles.
- Assert rst during ACC -> busy=0 immediately, no step_done; step_start while busy and a weight write while busy are both ignored, confirmed by read-back.
